inter_rr_arbiter: RTL
=====================

// Module: inter_rr_arbiter
// PURPOSE
//  Round-robin arbiter for the 3-master / 2-slave interconnect. Each master gets a
//  one-entry holding slot with backpressure (in_ready_k). The arbiter grants pending
//  masters fairly and drives a registered valid/addr/value transfer to the selected
//  slave. A per-transfer watchdog drops a transfer the slave never accepts.
//  Packet format: data[6] = slave select (0 = slave1, 1 = slave2), data[5:3] = addr,
//  data[2:0] = value.
// PARAMETERS
//  TIMEOUT   16   max SEND cycles without handshake before the transfer is dropped (>=2)
//  CNT_W     5    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk                 in   1  clock, rising edge
//  rst                 in   1  reset, asynchronous, active-high
//  in_valid_1/2/3      in   1  master k offers data_in_k this cycle
//  data_in_1/2/3       in   7  master k packet
//  in_ready_1/2/3      out  1  master k slot empty; capture only when valid && ready
//  ready_slave1/2      in   1  slave accepts the transfer
//  valid_slave1/2      out  1  transfer valid to slave 1/2 (registered, one-hot or zero)
//  addr_out            out  3  transfer address (registered)
//  value_out           out  3  transfer value (registered)
//  grant_id            out  2  granting master: 1/2/3; 0 when idle
//  done                out  1  1-cycle pulse the cycle after a slave handshake
//  err                 out  1  1-cycle pulse the cycle after a timeout drop
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All outputs 0, except in_ready_k = 1.
//   - pend_k = 0; state = IDLE; rr pointer ptr = 1; watchdog = 0.
//   - Reset mid-transfer discards every pending packet.
//  Slot:
//   - in_ready_k = !pend_k (combinational from the register).
//   - On an edge with in_valid_k && in_ready_k: slot_k <= data_in_k, pend_k <= 1.
//   - in_valid_k while not ready is ignored; the master must hold and retry.
//  FSM states: IDLE, SEND.
//   - IDLE, any pend_k set: grant the first pending master in order ptr, ptr+1, ptr+2
//     (mod 3, values 1..3). On the same edge load:
//     valid_slave{1|2} from slot[6], addr_out, value_out, grant_id, watchdog = 0;
//     go to SEND.
//   - IDLE, nothing pending: stay in IDLE; outputs held at 0.
//   - SEND, handshake (valid_slaveX && ready_slaveX at the edge):
//     clear pend_g; done <= 1; valid/addr/value/grant_id <= 0;
//     ptr <= g mod 3 + 1; go to IDLE.
//   - SEND, no handshake, watchdog == TIMEOUT-1: same as handshake, but err <= 1 and
//     done stays 0 (packet dropped).
//   - SEND, otherwise: watchdog++; all outputs held stable (valid never retracted).
//  Latency and throughput:
//   - Capture at edge E -> valid at edge E+1 if the arbiter is in IDLE.
//   - Minimum 2 cycles per transfer (IDLE gap between transfers).
//  Edge cases:
//   - Handshake and timeout on the same edge: handshake wins (done, not err).
//   - Ready on the unselected slave has no effect.
//   - A granted master's slot stays full (in_ready = 0) until its transfer completes or
//     is dropped. It can refill on the edge after clearing, never the same edge.
//   - New requests arriving during SEND only become eligible in the next IDLE.
//   - The slot is not overwritten while pending.
// TESTING
//  1. Reset, then master1 sends 7'b0_101_011 with ready_slave1 = 1
//     -> valid_slave1 = 1, addr_out = 5, value_out = 3, grant_id = 1; done 2 cycles
//     after capture.
//  2. All 3 masters valid on the same cycle, both slaves always ready
//     -> grants 1, 2, 3 in order, one every 2 cycles; each in_ready_k rises after its
//     done.
//  3. Master2 streams continuously and master1 sends once (ptr = 2 after a master1 grant)
//     -> master2 granted, then master1 is not starved: grant order 2, 1, 2.
//  4. Master3 sends 7'b1_010_001 with ready_slave2 held 0
//     -> valid_slave2 held 16 cycles; err pulse; valid drops; in_ready_3 = 1.
//  5. ready_slave2 rises exactly on the 16th SEND cycle
//     -> done = 1, err = 0.
//  6. rst asserted mid-SEND with 2 slots pending
//     -> all valids 0 immediately, all in_ready = 1; after release master1 wins first.

Source files
------------

// File: rtl/inter_rr_arbiter.sv
// inter_rr_arbiter: 3-master round-robin arbiter with one-entry slots, two slaves and a timeout watchdog
module inter_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_1,
  input  logic       in_valid_2,
  input  logic       in_valid_3,
  input  logic [6:0] data_in_1,
  input  logic [6:0] data_in_2,
  input  logic [6:0] data_in_3,
  output logic       in_ready_1,
  output logic       in_ready_2,
  output logic       in_ready_3,
  input  logic       ready_slave1,
  input  logic       ready_slave2,
  output logic       valid_slave1,
  output logic       valid_slave2,
  output logic [2:0] addr_out,
  output logic [2:0] value_out,
  output logic [1:0] grant_id,
  output logic       done,
  output logic       err
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [3:1] pend, vin;
  logic [3:0] pv;
  logic [6:0] slot [0:3];
  logic [6:0] din [0:3];
  logic [1:0] ptr, c1, c2, sel;
  logic [CNT_W-1:0] wd;
  logic hs, to, fin;
  assign vin = {in_valid_3, in_valid_2, in_valid_1};
  assign {in_ready_3, in_ready_2, in_ready_1} = ~pend;
  assign pv = {pend, 1'b0};
  assign din[0] = '0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;
  always_comb begin
    c1 = ptr == 2'd3 ? 2'd1 : ptr + 2'd1;
    c2 = c1 == 2'd3 ? 2'd1 : c1 + 2'd1;
    sel = pv[ptr] ? ptr : pv[c1] ? c1 : pv[c2] ? c2 : 2'd0;
    hs = (valid_slave1 && ready_slave1) || (valid_slave2 && ready_slave2);
    to = wd == CNT_W'(TIMEOUT - 1);
    fin = state == SEND && (hs || to);
    state_nxt = state == IDLE ? (sel != 2'd0 ? SEND : IDLE) : (fin ? IDLE : SEND);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      for (int k = 0; k < 4; k++) slot[k] <= '0;
      ptr <= 2'd1;
      wd <= '0;
      valid_slave1 <= 1'b0;
      valid_slave2 <= 1'b0;
      addr_out <= '0;
      value_out <= '0;
      grant_id <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= 1'b0;
      err <= 1'b0;
      for (int k = 1; k < 4; k++)
        if (fin && grant_id == 2'(k)) pend[k] <= 1'b0;
        else if (vin[k] && !pend[k]) begin
          pend[k] <= 1'b1;
          slot[k] <= din[k];
        end
      if (state == IDLE && sel != 2'd0) begin
        valid_slave1 <= !slot[sel][6];
        valid_slave2 <= slot[sel][6];
        addr_out <= slot[sel][5:3];
        value_out <= slot[sel][2:0];
        grant_id <= sel;
        wd <= '0;
      end else if (fin) begin
        done <= hs;
        err <= !hs;
        valid_slave1 <= 1'b0;
        valid_slave2 <= 1'b0;
        addr_out <= '0;
        value_out <= '0;
        grant_id <= '0;
        ptr <= grant_id == 2'd3 ? 2'd1 : grant_id + 2'd1;
      end else if (state == SEND) wd <= wd + CNT_W'(1);
    end
  end
endmodule
